// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control unit: sequences IF/ID/EXE/MEM/WB and drives the ALU
// controls, mux selects and datapath write enables from the current state and opcode.
module mc_control_unit #(
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] OP_HALT = 6'h3F
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            sign,
    output logic            PCWre,
    output logic            IRWre,
    output logic            InsMemRW,
    output logic            ALUSrcA,
    output logic            ALUSrcB,
    output logic [2:0]      ALUop,
    output logic            ExtSel,
    output logic            RegWre,
    output logic [1:0]      RegDst,
    output logic            WrRegDSrc,
    output logic            DBDataSrc,
    output logic            mRD,
    output logic            mWR,
    output logic [1:0]      PCSrc,
    output logic            halted
);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'b010011);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b110101);
    localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(6'b110110);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OP_JR    = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b111010);

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EXE_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_AL, S_WB_LD, S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       db_data_src;
        logic       m_rd;
        logic       m_wr;
        logic [1:0] pc_src;
        logic       halted;
    } ctl_t;

    state_t     state, next_state;
    ctl_t       ctl, ctl_out;
    logic       is_rtype, is_itype, is_branch, is_ls, taken;
    logic [2:0] alu_op_dec;
    logic       src_a_dec, src_b_dec, ext_dec;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        is_rtype   = 1'b0;
        is_itype   = 1'b0;
        is_branch  = 1'b0;
        is_ls      = 1'b0;
        alu_op_dec = 3'b000;
        src_a_dec  = 1'b0;
        src_b_dec  = 1'b0;
        ext_dec    = 1'b1;
        case (op)
            OP_ADD:   is_rtype = 1'b1;
            OP_SUB:   begin is_rtype = 1'b1; alu_op_dec = 3'b001; end
            OP_AND:   begin is_rtype = 1'b1; alu_op_dec = 3'b100; end
            OP_SLL:   begin is_rtype = 1'b1; alu_op_dec = 3'b010; src_a_dec = 1'b1; end
            OP_ADDIU: begin is_itype = 1'b1; src_b_dec = 1'b1; end
            OP_ANDI:  begin is_itype = 1'b1; alu_op_dec = 3'b100; src_b_dec = 1'b1; ext_dec = 1'b0; end
            OP_ORI:   begin is_itype = 1'b1; alu_op_dec = 3'b011; src_b_dec = 1'b1; ext_dec = 1'b0; end
            OP_XORI:  begin is_itype = 1'b1; alu_op_dec = 3'b111; src_b_dec = 1'b1; ext_dec = 1'b0; end
            OP_SLTI:  begin is_itype = 1'b1; alu_op_dec = 3'b110; src_b_dec = 1'b1; end
            OP_SW, OP_LW:          begin is_ls = 1'b1; src_b_dec = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLTZ: begin is_branch = 1'b1; alu_op_dec = 3'b001; end
            default: ;
        endcase
        taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero) ||
                ((op == OP_BLTZ) && sign);
    end

    always_comb begin
        ctl        = '0;
        next_state = state;
        if (state inside {S_EXE_AL, S_EXE_BR, S_EXE_LS}) begin
            ctl.alu_op    = alu_op_dec;
            ctl.alu_src_a = src_a_dec;
            ctl.alu_src_b = src_b_dec;
            ctl.ext_sel   = ext_dec;
        end
        case (state)
            S_IF: begin
                ctl.ir_wre     = 1'b1;
                ctl.ins_mem_rw = 1'b1;
                next_state     = S_ID;
            end
            S_ID: begin
                if (op == OP_HALT)             next_state = S_HALT;
                else if (is_branch)            next_state = S_EXE_BR;
                else if (is_ls)                next_state = S_EXE_LS;
                else if (is_rtype || is_itype) next_state = S_EXE_AL;
                else begin
                    // Jumps retire here; anything undecoded retires as a NOP.
                    ctl.pc_wre = 1'b1;
                    next_state = S_IF;
                    case (op)
                        OP_J:  ctl.pc_src = 2'b11;
                        OP_JR: ctl.pc_src = 2'b10;
                        OP_JAL: begin
                            ctl.pc_src  = 2'b11;
                            ctl.reg_wre = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_EXE_AL: next_state = S_WB_AL;
            S_EXE_BR: begin
                ctl.pc_wre = 1'b1;
                ctl.pc_src = taken ? 2'b01 : 2'b00;
                next_state = S_IF;
            end
            S_EXE_LS: next_state = S_MEM;
            S_MEM: begin
                if (op == OP_SW) begin
                    ctl.m_wr   = 1'b1;
                    ctl.pc_wre = 1'b1;
                    next_state = S_IF;
                end else begin
                    ctl.m_rd   = 1'b1;
                    next_state = S_WB_LD;
                end
            end
            S_WB_AL: begin
                ctl.reg_wre      = 1'b1;
                ctl.pc_wre       = 1'b1;
                ctl.reg_dst      = is_rtype ? 2'b10 : 2'b01;
                ctl.wr_reg_d_src = 1'b1;
                next_state       = S_IF;
            end
            S_WB_LD: begin
                ctl.reg_wre      = 1'b1;
                ctl.pc_wre       = 1'b1;
                ctl.reg_dst      = 2'b01;
                ctl.db_data_src  = 1'b1;
                ctl.wr_reg_d_src = 1'b1;
                next_state       = S_IF;
            end
            S_HALT: ctl.halted = 1'b1;
            default: next_state = S_IF;
        endcase
    end

    // NOTE: the state register uses non-blocking assignment; everything else here is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IF;
        else        state <= next_state;
    end

    // Reset gates the outputs directly so an aborted instruction stops writing at once.
    assign ctl_out = rst_n ? ctl : '0;

    assign PCWre     = ctl_out.pc_wre;
    assign IRWre     = ctl_out.ir_wre;
    assign InsMemRW  = ctl_out.ins_mem_rw;
    assign ALUSrcA   = ctl_out.alu_src_a;
    assign ALUSrcB   = ctl_out.alu_src_b;
    assign ALUop     = ctl_out.alu_op;
    assign ExtSel    = ctl_out.ext_sel;
    assign RegWre    = ctl_out.reg_wre;
    assign RegDst    = ctl_out.reg_dst;
    assign WrRegDSrc = ctl_out.wr_reg_d_src;
    assign DBDataSrc = ctl_out.db_data_src;
    assign mRD       = ctl_out.m_rd;
    assign mWR       = ctl_out.m_wr;
    assign PCSrc     = ctl_out.pc_src;
    assign halted    = ctl_out.halted;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: vector table, hand-written corner sequences and
// randomized instruction streams against a per-instruction cycle model.
module tb_mc_control_unit;

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010,
                           AND_ = 6'b010000, ANDI = 6'b010001, ORI = 6'b010010,
                           XORI = 6'b010011, SLL = 6'b011000, SLTI = 6'b100110,
                           SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100,
                           BNE = 6'b110101, BLTZ = 6'b110110, J = 6'b111000,
                           JR = 6'b111001, JAL = 6'b111010, HALT = 6'h3F;

    typedef struct packed {
        logic       pc_wre;
        logic       ir_wre;
        logic       ins_mem_rw;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic       wr_reg_d_src;
        logic       db_data_src;
        logic       m_rd;
        logic       m_wr;
        logic [1:0] pc_src;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        logic       sign;
        int         cycles;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic [1:0] reg_dst;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = ADD;
    logic       zero = 1'b0, sign = 1'b0;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre;
    logic       WrRegDSrc, DBDataSrc, mRD, mWR, halted;
    logic [2:0] ALUop;
    logic [1:0] RegDst, PCSrc;
    ctl_t       obs;
    int         total = 0;
    int         bad = 0;

    mc_control_unit dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUop(ALUop), .ExtSel(ExtSel), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD),
        .mWR(mWR), .PCSrc(PCSrc), .halted(halted)
    );

    always #5 clk = ~clk;

    assign obs = {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUop, ExtSel, RegWre,
                  RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, halted};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] alu_code(input logic [5:0] o);
        case (o)
            SUB, BEQ, BNE, BLTZ: return 3'b001;
            SLL:                 return 3'b010;
            ORI:                 return 3'b011;
            AND_, ANDI:          return 3'b100;
            SLTI:                return 3'b110;
            XORI:                return 3'b111;
            default:             return 3'b000;
        endcase
    endfunction

    // Expected outputs for cycle k (0 = fetch) of an instruction with opcode o.
    function automatic ctl_t model(input logic [5:0] o, input int k, input logic z, input logic s);
        ctl_t c;
        bit is_r, is_i, is_br, is_mem;
        c      = '0;
        is_r   = o inside {ADD, SUB, AND_, SLL};
        is_i   = o inside {ADDIU, ANDI, ORI, XORI, SLTI};
        is_br  = o inside {BEQ, BNE, BLTZ};
        is_mem = o inside {LW, SW};
        if (k == 0) begin
            c.ir_wre     = 1'b1;
            c.ins_mem_rw = 1'b1;
        end else if (k == 1) begin
            if (o == J)        begin c.pc_wre = 1'b1; c.pc_src = 2'b11; end
            else if (o == JR)  begin c.pc_wre = 1'b1; c.pc_src = 2'b10; end
            else if (o == JAL) begin c.pc_wre = 1'b1; c.pc_src = 2'b11; c.reg_wre = 1'b1; end
            else if (!(is_r || is_i || is_br || is_mem || o == HALT)) c.pc_wre = 1'b1;
        end else if (o == HALT) begin
            c.halted = 1'b1;
        end else if (k == 2) begin
            c.alu_op    = alu_code(o);
            c.alu_src_a = (o == SLL);
            c.alu_src_b = is_i || is_mem;
            c.ext_sel   = !(o inside {ANDI, ORI, XORI});
            if (is_br) begin
                c.pc_wre = 1'b1;
                c.pc_src = ((o == BEQ && z) || (o == BNE && !z) || (o == BLTZ && s)) ? 2'b01 : 2'b00;
            end
        end else if (k == 3) begin
            if (o == SW)      begin c.m_wr = 1'b1; c.pc_wre = 1'b1; end
            else if (o == LW) c.m_rd = 1'b1;
            else begin
                c.reg_wre      = 1'b1;
                c.pc_wre       = 1'b1;
                c.reg_dst      = is_r ? 2'b10 : 2'b01;
                c.wr_reg_d_src = 1'b1;
            end
        end else begin
            c.reg_wre      = 1'b1;
            c.pc_wre       = 1'b1;
            c.reg_dst      = 2'b01;
            c.db_data_src  = 1'b1;
            c.wr_reg_d_src = 1'b1;
        end
        return c;
    endfunction

    function automatic int inst_len(input logic [5:0] o);
        if (o == LW) return 5;
        if (o inside {BEQ, BNE, BLTZ}) return 3;
        if (o inside {ADD, SUB, AND_, SLL, ADDIU, ANDI, ORI, XORI, SLTI, SW}) return 4;
        return 2;
    endfunction

    task automatic run_cycles(input logic [5:0] o, input int first, input int last,
                              input bit rnd, input logic z, input logic s, input string tag);
        for (int k = first; k <= last; k++) begin
            @(negedge clk);
            op = o;
            if (rnd) begin
                zero = 1'($urandom);
                sign = 1'($urandom);
            end else begin
                zero = z;
                sign = s;
            end
            #1;
            check($sformatf("%s op=%h cyc%0d", tag, o, k), obs, model(o, k, zero, sign));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         cycles = 0;
        logic [2:0] alu_seen = 3'b000;
        logic [1:0] pc_src_seen = 2'b00, dst_seen = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            op = v.op;
            zero = v.zero;
            sign = v.sign;
            #1;
            check($sformatf("vec op=%h wre_excl cyc%0d", v.op, k), {31'd0, RegWre & mWR}, 32'd0);
            if (k == 2) alu_seen = ALUop;
            if (PCWre) begin
                cycles = k + 1;
                pc_src_seen = PCSrc;
                dst_seen = RegDst;
                break;
            end
        end
        check($sformatf("vec op=%h z=%b s=%b cycles", v.op, v.zero, v.sign), cycles, v.cycles);
        check($sformatf("vec op=%h z=%b s=%b pcsrc", v.op, v.zero, v.sign), pc_src_seen, v.pc_src);
        check($sformatf("vec op=%h aluop", v.op), alu_seen, v.alu_op);
        check($sformatf("vec op=%h regdst", v.op), dst_seen, v.reg_dst);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[21];
        logic [5:0] defined_ops[17];
        logic [5:0] o;

        vecs = '{
            '{ADD,   0, 0, 4, 2'b00, 3'b000, 2'b10},
            '{SUB,   0, 0, 4, 2'b00, 3'b001, 2'b10},
            '{AND_,  0, 0, 4, 2'b00, 3'b100, 2'b10},
            '{SLL,   0, 0, 4, 2'b00, 3'b010, 2'b10},
            '{ADDIU, 0, 0, 4, 2'b00, 3'b000, 2'b01},
            '{ANDI,  0, 0, 4, 2'b00, 3'b100, 2'b01},
            '{ORI,   0, 0, 4, 2'b00, 3'b011, 2'b01},
            '{XORI,  0, 0, 4, 2'b00, 3'b111, 2'b01},
            '{SLTI,  0, 0, 4, 2'b00, 3'b110, 2'b01},
            '{BEQ,   1, 0, 3, 2'b01, 3'b001, 2'b00},
            '{BEQ,   0, 0, 3, 2'b00, 3'b001, 2'b00},
            '{BNE,   0, 1, 3, 2'b01, 3'b001, 2'b00},
            '{BNE,   1, 0, 3, 2'b00, 3'b001, 2'b00},
            '{BLTZ,  0, 1, 3, 2'b01, 3'b001, 2'b00},
            '{BLTZ,  1, 0, 3, 2'b00, 3'b001, 2'b00},
            '{LW,    0, 0, 5, 2'b00, 3'b000, 2'b01},
            '{SW,    0, 0, 4, 2'b00, 3'b000, 2'b00},
            '{JAL,   0, 0, 2, 2'b11, 3'b000, 2'b00},
            '{J,     0, 0, 2, 2'b11, 3'b000, 2'b00},
            '{JR,    0, 0, 2, 2'b10, 3'b000, 2'b00},
            '{6'h2A, 0, 0, 2, 2'b00, 3'b000, 2'b00}
        };
        defined_ops = '{ADD, SUB, ADDIU, AND_, ANDI, ORI, XORI, SLL, SLTI,
                        SW, LW, BEQ, BNE, BLTZ, J, JR, JAL};

        // Reset holds every output low; release lands in fetch.
        @(negedge clk); #1;
        check("reset_outputs", obs, 32'd0);
        @(negedge clk); #1;
        check("reset_outputs_hold", obs, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_irwre", {31'd0, IRWre}, 32'd1);
        check("release_pcwre", {31'd0, PCWre}, 32'd0);
        check("release_fetch", obs, model(ADD, 0, zero, sign));
        run_cycles(ADD, 1, 3, 1'b0, 1'b0, 1'b0, "post_reset");

        // Full per-cycle trace of the lw, sw and jal sequences.
        run_cycles(LW, 0, 4, 1'b0, 1'b0, 1'b0, "lw_trace");
        run_cycles(SW, 0, 3, 1'b0, 1'b0, 1'b0, "sw_trace");
        run_cycles(JAL, 0, 1, 1'b0, 1'b0, 1'b0, "jal_trace");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Halt parks the FSM until reset.
        run_cycles(HALT, 0, 1, 1'b0, 1'b0, 1'b0, "halt_entry");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            zero = 1'($urandom);
            sign = 1'($urandom);
            #1;
            check($sformatf("halt_hold cyc%0d", i), obs, model(HALT, 2 + i, zero, sign));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("halt_reset", obs, 32'd0);
        @(negedge clk);
        op = ADD;
        rst_n = 1'b1;
        #1;
        check("halt_restart_fetch", obs, model(ADD, 0, zero, sign));
        run_cycles(ADD, 1, 3, 1'b0, 1'b0, 1'b0, "halt_restart");

        // Reset asserted during the lw memory cycle aborts it immediately.
        run_cycles(LW, 0, 3, 1'b0, 1'b0, 1'b0, "lw_abort_pre");
        #1;
        rst_n = 1'b0;
        #1;
        check("lw_abort_mrd", {31'd0, mRD}, 32'd0);
        check("lw_abort_all", obs, 32'd0);
        @(negedge clk); #1;
        check("lw_abort_hold", obs, 32'd0);
        op = ADD;
        rst_n = 1'b1;
        #1;
        check("lw_abort_restart_fetch", obs, model(ADD, 0, zero, sign));
        run_cycles(ADD, 1, 3, 1'b0, 1'b0, 1'b0, "lw_abort_restart");

        // Random instruction stream with random flags every cycle.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(9) < 7) o = defined_ops[$urandom_range(16)];
            else begin
                o = 6'($urandom);
                if (o == HALT) o = 6'h2A;
            end
            run_cycles(o, 0, inst_len(o) - 1, 1'b1, 1'b0, 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
